// File: rtl/hazard_track_unit.sv
// Hazard tracking for the 5-stage pipeline: shadow E/M/W destination info, forwarding selects, stalls.
// Optional macro DECODE_WB_FWD_EN enables ResultW forwarding into the decode-stage operand muxes.
module hazard_track_unit #(
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] RsD,
   input  logic [REG_AW-1:0] RtD,
   input  logic [REG_AW-1:0] WriteRegD,
   input  logic              RegWriteD,
   input  logic              MemtoRegD,
   input  logic              BranchD,
   output logic [1:0]        ForwardAD,
   output logic [1:0]        ForwardBD,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushE
);

   logic [REG_AW-1:0] RsE_q, RsE_d, RtE_q, RtE_d, WriteRegE_q, WriteRegE_d;
   logic              RegWriteE_q, RegWriteE_d, MemtoRegE_q, MemtoRegE_d;
   logic [REG_AW-1:0] WriteRegM_q, WriteRegM_d;
   logic              RegWriteM_q, RegWriteM_d, MemtoRegM_q, MemtoRegM_d;
   logic [REG_AW-1:0] WriteRegW_q, WriteRegW_d;
   logic              RegWriteW_q, RegWriteW_d;

   logic lwstall, branchstall, stall;

   // Register $0 is hardwired, so it never produces a hazard.
   function automatic logic reg_match(input logic [REG_AW-1:0] r,
                                      input logic [REG_AW-1:0] wr,
                                      input logic              we);
      return (r != '0) && we && (wr == r);
   endfunction

   always_comb begin
      RsE_d       = RsD;
      RtE_d       = RtD;
      WriteRegE_d = WriteRegD;
      RegWriteE_d = RegWriteD;
      MemtoRegE_d = MemtoRegD;
      if (stall) begin
         RsE_d       = '0;
         RtE_d       = '0;
         WriteRegE_d = '0;
         RegWriteE_d = 1'b0;
         MemtoRegE_d = 1'b0;
      end
      WriteRegM_d = WriteRegE_q;
      RegWriteM_d = RegWriteE_q;
      MemtoRegM_d = MemtoRegE_q;
      WriteRegW_d = WriteRegM_q;
      RegWriteW_d = RegWriteM_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         RsE_q       <= '0;
         RtE_q       <= '0;
         WriteRegE_q <= '0;
         RegWriteE_q <= 1'b0;
         MemtoRegE_q <= 1'b0;
         WriteRegM_q <= '0;
         RegWriteM_q <= 1'b0;
         MemtoRegM_q <= 1'b0;
         WriteRegW_q <= '0;
         RegWriteW_q <= 1'b0;
      end else begin
         RsE_q       <= RsE_d;
         RtE_q       <= RtE_d;
         WriteRegE_q <= WriteRegE_d;
         RegWriteE_q <= RegWriteE_d;
         MemtoRegE_q <= MemtoRegE_d;
         WriteRegM_q <= WriteRegM_d;
         RegWriteM_q <= RegWriteM_d;
         MemtoRegM_q <= MemtoRegM_d;
         WriteRegW_q <= WriteRegW_d;
         RegWriteW_q <= RegWriteW_d;
      end
   end

   always_comb begin
      ForwardAD = 2'd0;
      ForwardBD = 2'd0;
`ifdef DECODE_WB_FWD_EN
      if (reg_match(RsD, WriteRegM_q, RegWriteM_q))      ForwardAD = 2'd1;
      else if (reg_match(RsD, WriteRegW_q, RegWriteW_q)) ForwardAD = 2'd2;
      if (reg_match(RtD, WriteRegM_q, RegWriteM_q))      ForwardBD = 2'd1;
      else if (reg_match(RtD, WriteRegW_q, RegWriteW_q)) ForwardBD = 2'd2;
`else
      // W-stage results reach decode through register-file write-before-read.
      if (reg_match(RsD, WriteRegM_q, RegWriteM_q)) ForwardAD = 2'd1;
      if (reg_match(RtD, WriteRegM_q, RegWriteM_q)) ForwardBD = 2'd1;
`endif
   end

   always_comb begin
      ForwardAE = 2'd0;
      ForwardBE = 2'd0;
      if (reg_match(RsE_q, WriteRegM_q, RegWriteM_q))      ForwardAE = 2'd2;
      else if (reg_match(RsE_q, WriteRegW_q, RegWriteW_q)) ForwardAE = 2'd1;
      if (reg_match(RtE_q, WriteRegM_q, RegWriteM_q))      ForwardBE = 2'd2;
      else if (reg_match(RtE_q, WriteRegW_q, RegWriteW_q)) ForwardBE = 2'd1;
   end

   always_comb begin
      lwstall = MemtoRegE_q &&
                (reg_match(RsD, WriteRegE_q, RegWriteE_q) ||
                 reg_match(RtD, WriteRegE_q, RegWriteE_q));
      // A branch after a load waits two cycles: first on the E match, then on the M-load match.
      branchstall = BranchD &&
                    (reg_match(RsD, WriteRegE_q, RegWriteE_q) ||
                     reg_match(RtD, WriteRegE_q, RegWriteE_q) ||
                     (MemtoRegM_q &&
                      (reg_match(RsD, WriteRegM_q, RegWriteM_q) ||
                       reg_match(RtD, WriteRegM_q, RegWriteM_q))));
      stall  = lwstall || branchstall;
      StallF = stall;
      StallD = stall;
      FlushE = stall;
   end

endmodule

// File: tb/tb_hazard_track_unit.sv
// Directed bench for hazard_track_unit: expected outputs are queued when a step is driven
// and popped/compared at the following falling edge.
module tb_hazard_track_unit;

   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] RsD, RtD, WriteRegD;
   logic          RegWriteD, MemtoRegD, BranchD;
   logic [1:0]    ForwardAD, ForwardBD, ForwardAE, ForwardBE;
   logic          StallF, StallD, FlushE;

   typedef struct packed {
      logic [1:0] ad;
      logic [1:0] bd;
      logic [1:0] ae;
      logic [1:0] be;
      logic       st;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

`ifdef DECODE_WB_FWD_EN
   localparam logic [1:0] AD_WB = 2'd2;
`else
   localparam logic [1:0] AD_WB = 2'd0;
`endif

   hazard_track_unit #(.REG_AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .RsD       (RsD),
      .RtD       (RtD),
      .WriteRegD (WriteRegD),
      .RegWriteD (RegWriteD),
      .MemtoRegD (MemtoRegD),
      .BranchD   (BranchD),
      .ForwardAD (ForwardAD),
      .ForwardBD (ForwardBD),
      .ForwardAE (ForwardAE),
      .ForwardBE (ForwardBE),
      .StallF    (StallF),
      .StallD    (StallD),
      .FlushE    (FlushE)
   );

   always #5 clk = ~clk;

   function automatic exp_t ex(input logic [1:0] ad, input logic [1:0] bd,
                               input logic [1:0] ae, input logic [1:0] be,
                               input logic st);
      exp_t e;
      e.ad = ad; e.bd = bd; e.ae = ae; e.be = be; e.st = st;
      return e;
   endfunction

   task automatic cmp(input string tag, input string fld,
                      input logic [1:0] obs, input logic [1:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, expv);
      end
   endtask

   task automatic chk(input string tag);
      exp_t e;
      checks++;
      assert (exp_q.size() != 0) else begin
         failures++;
         $error("FAIL %s.queue observed=empty expected=entry", tag);
         return;
      end
      e = exp_q.pop_front();
      cmp(tag, "ForwardAD", ForwardAD, e.ad);
      cmp(tag, "ForwardBD", ForwardBD, e.bd);
      cmp(tag, "ForwardAE", ForwardAE, e.ae);
      cmp(tag, "ForwardBE", ForwardBE, e.be);
      cmp(tag, "StallF", {1'b0, StallF}, {1'b0, e.st});
      cmp(tag, "StallD", {1'b0, StallD}, {1'b0, e.st});
      cmp(tag, "FlushE", {1'b0, FlushE}, {1'b0, e.st});
   endtask

   task automatic drive(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [AW-1:0] wr, input logic rw, input logic mr,
                        input logic br, input exp_t e);
      RsD = rs; RtD = rt; WriteRegD = wr;
      RegWriteD = rw; MemtoRegD = mr; BranchD = br;
      exp_q.push_back(e);
   endtask

   // One pipeline cycle: inputs driven at posedge+1, outputs checked at negedge.
   task automatic step(input string tag, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] wr, input logic rw, input logic mr,
                       input logic br, input exp_t e);
      drive(rs, rt, wr, rw, mr, br, e);
      @(negedge clk);
      chk(tag);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));
      #3;
      chk("rst_init");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      step("post_rst_rs5", 5, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));

      // ALU dependency on $8
      step("alu_add8",   1, 2, 8,  1, 0, 0, ex(0, 0, 0, 0, 0));
      step("alu_use8",   8, 3, 12, 1, 0, 0, ex(0, 0, 0, 0, 0));
      step("alu_m_fwd",  8, 0, 0,  0, 0, 0, ex(1, 0, 2, 0, 0));
      step("alu_w_fwd",  0, 0, 0,  0, 0, 0, ex(0, 0, 1, 0, 0));

      // Load-use on $9
      step("lw9",        4, 9, 9,  1, 1, 0, ex(0, 0, 0, 0, 0));
      step("lw9_stall",  6, 9, 13, 1, 0, 0, ex(0, 0, 0, 0, 1));
      step("lw9_resume", 6, 9, 13, 1, 0, 0, ex(0, 1, 0, 0, 0));
      step("lw9_be_w",   0, 0, 0,  0, 0, 0, ex(0, 0, 0, 1, 0));

      // Branch after load on $10: two stall cycles
      step("lw10",       4, 10, 10, 1, 1, 0, ex(0, 0, 0, 0, 0));
      step("br_lw_st1",  10, 0, 0,  0, 0, 1, ex(0, 0, 0, 0, 1));
      step("br_lw_st2",  10, 0, 0,  0, 0, 1, ex(1, 0, 0, 0, 1));
      step("br_lw_go",   10, 0, 0,  0, 0, 1, ex(AD_WB, 0, 0, 0, 0));

      // Branch after ALU op on $11: one stall cycle
      step("add11",      1, 2, 11, 1, 0, 0, ex(0, 0, 0, 0, 0));
      step("br_alu_st",  3, 11, 0,  0, 0, 1, ex(0, 0, 0, 0, 1));
      step("br_alu_go",  3, 11, 0,  0, 0, 1, ex(0, 1, 0, 0, 0));

      // Register zero never matches
      step("lw_r0",      1, 2, 0,  1, 1, 0, ex(0, 0, 0, 1, 0));
      step("r0_use_e",   0, 0, 0,  0, 0, 1, ex(0, 0, 0, 0, 0));
      step("r0_use_m",   0, 0, 0,  0, 0, 1, ex(0, 0, 0, 0, 0));

      // Asynchronous reset while a load sits in E
      step("lw9b",       4, 9, 9,  1, 1, 0, ex(0, 0, 0, 0, 0));
      drive(9, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 1));
      @(negedge clk);
      chk("mid_stall");
      #1;
      reset = 1'b1;
      exp_q.push_back(ex(0, 0, 0, 0, 0));
      #1;
      chk("mid_rst");
      drive(5, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));
      #1;
      chk("mid_rst_rs5");
      reset = 1'b0;
      @(posedge clk);
      #1;
      step("mid_rst_rel", 5, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_track_unit.md
Name: hazard_track_unit

Overview:
- Producer side of the decode- and execute-stage operand forwarding paths in the 5-stage pipelined CPU.
- Keeps its own shadow pipeline of destination-register info (E, M, W) from decode-stage inputs.
- From that state it generates the ForwardAD/ForwardBD selects consumed by the decode-stage forwarding muxes, the ForwardAE/ForwardBE selects for the execute-stage muxes, and the load-use/branch stall and flush controls.

Parameters:
- REG_AW, 5, register-number width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all shadow stage state.
- RsD  input  REG_AW  decode-stage source register A.
- RtD  input  REG_AW  decode-stage source register B.
- WriteRegD  input  REG_AW  decode-stage destination register, already resolved from rt/rd.
- RegWriteD  input  1  decode-stage instruction writes the register file.
- MemtoRegD  input  1  decode-stage instruction is a load.
- BranchD  input  1  decode-stage instruction is a branch compared in decode.
- ForwardAD  output  2  decode operand A select: 0 = RD1, 1 = ALUOutM, 2 = ResultW.
- ForwardBD  output  2  decode operand B select, same encoding as ForwardAD.
- ForwardAE  output  2  execute operand A select: 0 = register value, 1 = ResultW, 2 = ALUOutM.
- ForwardBE  output  2  execute operand B select, same encoding as ForwardAE.
- StallF  output  1  hold PC.
- StallD  output  1  hold IF/ID register.
- FlushE  output  1  insert bubble into ID/EX.

Behaviour:
- Shadow state registers:
  - E stage: RsE, RtE, WriteRegE, RegWriteE, MemtoRegE.
  - M stage: WriteRegM, RegWriteM, MemtoRegM.
  - W stage: WriteRegW, RegWriteW.
- Reset (asynchronous, any time, including mid-stall): all shadow registers go to 0. All outputs then evaluate to 0 in the same cycle, because they are combinational from state and inputs.
- Per rising clk edge, when not in reset:
  - If FlushE = 1, the E stage loads a bubble (all fields 0).
  - Otherwise the E stage loads RsD, RtD, WriteRegD, RegWriteD, MemtoRegD.
  - M loads from E unconditionally; W loads from M unconditionally.
  - StallD does not gate E; the bubble comes from FlushE.
- Match rule: register X matches stage S only if X != 0, RegWriteS = 1, and WriteRegS == X. Register 0 never forwards or stalls.
- ForwardAD (ForwardBD identical, using RtD):
  - 1 if RsD matches M.
  - Else 2 if RsD matches W (only when the optional feature is compiled in).
  - Else 0.
  - M has priority over W.
- ForwardAE (ForwardBE identical, using RtE):
  - 2 if RsE matches M.
  - Else 1 if RsE matches W.
  - Else 0.
  - M has priority over W.
- lwstall = MemtoRegE AND (RsD or RtD matches E).
- branchstall = BranchD AND (RsD or RtD matches E, or (MemtoRegM AND RsD or RtD matches M)).
- StallF = StallD = FlushE = lwstall OR branchstall. The outputs are combinational; they take effect at the next edge.
- Stall duration:
  - Load-use: exactly 1 cycle.
  - Branch after ALU op: 1 cycle.
  - Branch after load: 2 cycles, first via E match then via M-load match.
- ForwardAD/BD may be nonzero during a stall cycle; the consumer ignores them while StallD = 1.
- Simultaneous load in E and branch dependency: a single stall signal, no double counting.

Optional Feature:
- Macro: DECODE_WB_FWD_EN.
- Defined: ForwardAD/BD may select 2 (ResultW) on a W-stage match.
- Undefined: ForwardAD/BD never equal 2. W-stage values reach decode through the register file write-before-read, and the W match comparators are not built.
- ForwardAE/BE are unaffected by the macro.

Test Plan:
- Reset: assert reset mid-run with a load in E → all outputs 0 immediately. After release with RsD = 5 and no prior writes → ForwardAD = 0, StallF = 0.
- ALU dependency: add to $8, then next cycle RsD = 8 (no branch). The following cycle RsE = 8 with $8 in M → ForwardAE = 2, no stall. One cycle later with $8 in W → ForwardAE = 1.
- Load-use: lw to $9, then next instruction RtD = 9 → StallF = StallD = FlushE = 1 for exactly 1 cycle. Then ForwardBE = 1 when the lw is in W.
- Branch after load: lw to $10, then beq with RsD = 10 → stall for 2 consecutive cycles. On the 3rd cycle ForwardAD = 2 with DECODE_WB_FWD_EN defined, 0 without it; stall = 0.
- Branch after ALU op: add to $11, then beq with RtD = 11 → 1 stall cycle, then ForwardBD = 1 (ALUOutM).
- Register zero: instruction writes $0, then a dependent read with RsD = 0 → no stall, all forwards 0.
